// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - receive-only I2C slave: synchronizes SCL/SDA, ACKs its
// address and every data byte, and strobes each received byte out.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] data_slave_read,
  output logic       data_slave_read_valid,
  output logic       start,
  output logic       stop,
  output logic       addr_match,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_cond, stop_cond;

  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_full_q, byte_full_d;
  logic       sda_oe_d, addr_match_d, busy_d;
  logic [7:0] data_d;
  logic       valid_d, start_d, stop_d;

  // Synchronizers reset to 1 so an idle bus is seen during and after reset.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;
  assign sda_rise   = sda_s & ~sda_prev;
  assign sda_fall   = ~sda_s & sda_prev;
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q               <= IDLE;
      shift_q               <= 8'h00;
      bit_cnt_q             <= 3'd0;
      byte_full_q           <= 1'b0;
      sda_oe                <= 1'b0;
      addr_match            <= 1'b0;
      busy                  <= 1'b0;
      data_slave_read       <= 8'h00;
      data_slave_read_valid <= 1'b0;
      start                 <= 1'b0;
      stop                  <= 1'b0;
    end else begin
      state_q               <= state_d;
      shift_q               <= shift_d;
      bit_cnt_q             <= bit_cnt_d;
      byte_full_q           <= byte_full_d;
      sda_oe                <= sda_oe_d;
      addr_match            <= addr_match_d;
      busy                  <= busy_d;
      data_slave_read       <= data_d;
      data_slave_read_valid <= valid_d;
      start                 <= start_d;
      stop                  <= stop_d;
    end
  end

  // byte_full marks "8 bits sampled, waiting for the SCL fall that opens the ACK slot".
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_full_d  = byte_full_q;
    sda_oe_d     = sda_oe;
    addr_match_d = addr_match;
    busy_d       = busy;
    data_d       = data_slave_read;
    valid_d      = 1'b0;
    start_d      = 1'b0;
    stop_d       = 1'b0;

    if (start_cond) begin
      start_d      = 1'b1;
      busy_d       = 1'b1;
      addr_match_d = 1'b0;
      bit_cnt_d    = 3'd0;
      byte_full_d  = 1'b0;
      state_d      = ADDR;
    end else if (stop_cond) begin
      stop_d       = 1'b1;
      busy_d       = 1'b0;
      addr_match_d = 1'b0;
      sda_oe_d     = 1'b0;
      byte_full_d  = 1'b0;
      state_d      = IDLE;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise && !byte_full_q) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_full_d = 1'b1;
          end else if (scl_fall && byte_full_q) begin
            byte_full_d = 1'b0;
            if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
              sda_oe_d     = 1'b1;
              addr_match_d = 1'b1;
              state_d      = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = DATA;
          end
        end
        DATA: begin
          if (scl_rise && !byte_full_q) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_full_d = 1'b1;
              data_d      = {shift_q[6:0], sda_s};
              valid_d     = 1'b1;
            end
          end else if (scl_fall && byte_full_q) begin
            byte_full_d = 1'b0;
            sda_oe_d    = 1'b1;
            state_d     = DATA_ACK;
          end
        end
        IGNORE: sda_oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
